// File: rtl/serial_cmd_pkg.sv
// Shared definitions for the serial command engine: opcode and FSM state
// encodings, per-opcode argument counts and fixed reply lengths.
package serial_cmd_pkg;

  typedef enum logic [7:0] {
    OP_VERSION         = 8'd0,
    OP_SET_OUTPUTS     = 8'd1,
    OP_SET_PLL         = 8'd2,
    OP_SET_PASSTHROUGH = 8'd3,
    OP_SEND_HISTOGRAM  = 8'd4,
    OP_SET_PMT_VETO    = 8'd5,
    OP_RESET_PLL       = 8'd6,
    OP_SET_TEST_INPUTS = 8'd7,
    OP_READ_STATUS     = 8'd8
  } opcode_e;

  localparam logic [7:0] OP_MAX = 8'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARGS,
    S_EXEC,
    S_TX_LOAD,
    S_TX_WAIT,
    S_PLL_UPD
  } state_e;

  // SET_PLL's table entry is unused: its count comes from the NUM_PLL parameter.
  localparam int ARG_COUNT [0:8] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
  localparam int STATUS_LEN  = 2;
  localparam int VERSION_LEN = 1;

  function automatic int argCount(input logic [7:0] op, input int numPll);
    int n;
    n = 0;
    if (op == OP_SET_PLL) n = numPll;
    else if (op <= OP_MAX) n = ARG_COUNT[op[3:0]];
    return n;
  endfunction

endpackage

// File: rtl/hist_snapshot_mux.sv
// Histogram snapshot register with a byte-select mux for the reply stream.
module hist_snapshot_mux #(
  parameter int NUM_HIST = 32,
  parameter int HIST_W   = 32,
  parameter int IDX_W    = 7
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_load,
  input  logic [NUM_HIST*HIST_W-1:0] i_hist,
  input  logic [IDX_W-1:0]           i_idx,
  output logic [7:0]                 o_byte
);

  logic [NUM_HIST*HIST_W-1:0] r_snap;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_snap <= '0;
    else if (i_load) r_snap <= i_hist;
  end

  // Channels are contiguous and little-endian, so reply byte b is bits [b*8 +: 8].
  assign o_byte = r_snap[{i_idx, 3'b000} +: 8];

endmodule

// File: rtl/serial_cmd_engine.sv
// Byte-oriented command decoder: collects opcode arguments, applies configuration
// actions, and streams replies (version, status, histogram snapshot) to the UART.
module serial_cmd_engine
  import serial_cmd_pkg::*;
#(
  parameter int         NUM_HIST   = 32,
  parameter int         HIST_W     = 32,
  parameter int         NUM_PLL    = 6,
  parameter int         TIMEOUT    = 1000000,
  parameter logic [7:0] FW_VERSION = 8'd24
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       rx_ready,
  input  logic [7:0]                 rx_data,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  input  logic [NUM_HIST*HIST_W-1:0] hist_flat,
  output logic                       resethist,
  output logic                       disable_line_drivers,
  output logic                       enable_debug_outputs,
  output logic                       passthrough,
  output logic [2:0]                 vetopmtlast,
  output logic                       use_internal_test_pulse,
  output logic                       use_external_test_pulse,
  output logic [NUM_PLL*8-1:0]       pll_shifts,
  output logic                       updatepll,
  output logic                       busy,
  output logic [7:0]                 err_count
);

  localparam int HIST_BYTES = NUM_HIST * HIST_W / 8;
  localparam int IDX_W      = (HIST_BYTES > 2) ? $clog2(HIST_BYTES) : 1;
  localparam int ARG_W      = $clog2(NUM_PLL + 1);
  localparam int TMR_W      = $clog2(TIMEOUT + 1);

  state_e                   r_state, w_nextState;
  logic [7:0]               r_opcode;
  logic [NUM_PLL*8-1:0]     r_args;
  logic [(NUM_PLL+1)*8-1:0] w_argShift;
  logic [7:0]               w_a0;
  logic [ARG_W-1:0]         r_argIdx, w_newArgs, w_curArgs;
  logic [TMR_W-1:0]         r_timer;
  logic [IDX_W-1:0]         r_txIdx, r_lastIdx;
  logic [7:0]               w_histByte, w_replyByte, r_txData, r_errCount;
  logic                     r_txStart, r_resetHist, w_snapLoad, w_badOp, w_timeout;
  logic                     r_disable, r_debug, r_passthrough, r_intPulse, r_extPulse;
  logic [2:0]               r_veto;
  logic [NUM_PLL*8-1:0]     r_pll;

  assign w_newArgs  = ARG_W'(argCount(rx_data, NUM_PLL));
  assign w_curArgs  = ARG_W'(argCount(r_opcode, NUM_PLL));
  // Arguments shift in from the top, so a0 of a one-byte command sits in the top byte
  // and a full SET_PLL sequence ends with a[i] at byte i.
  assign w_argShift = {rx_data, r_args};
  assign w_a0       = r_args[NUM_PLL*8-1 -: 8];
  assign w_snapLoad = (r_state == S_EXEC) && (r_opcode == OP_SEND_HISTOGRAM);

  hist_snapshot_mux #(
    .NUM_HIST (NUM_HIST),
    .HIST_W   (HIST_W),
    .IDX_W    (IDX_W)
  ) u_hist (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .i_load    (w_snapLoad),
    .i_hist    (hist_flat),
    .i_idx     (r_txIdx),
    .o_byte    (w_histByte)
  );

  always_comb begin
    w_replyByte = FW_VERSION;
    if (r_opcode == OP_SEND_HISTOGRAM) w_replyByte = w_histByte;
    else if (r_opcode == OP_READ_STATUS)
      w_replyByte = (r_txIdx == '0) ? r_errCount : {7'b0, r_passthrough};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    w_badOp     = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:
        if (rx_ready) begin
          if (rx_data > OP_MAX) w_badOp = 1'b1;
          else if (w_newArgs != '0) w_nextState = S_ARGS;
          else w_nextState = S_EXEC;
        end
      S_ARGS:
        if (rx_ready) begin
          if (r_argIdx == w_curArgs - ARG_W'(1)) w_nextState = S_EXEC;
        end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_nextState = S_IDLE;
        end
      S_EXEC:
        case (r_opcode)
          OP_VERSION, OP_SEND_HISTOGRAM, OP_READ_STATUS: w_nextState = S_TX_LOAD;
          OP_SET_PLL, OP_RESET_PLL:                      w_nextState = S_PLL_UPD;
          default:                                       w_nextState = S_IDLE;
        endcase
      S_TX_LOAD:
        if (!tx_busy) w_nextState = S_TX_WAIT;
      // The first TX_WAIT cycle carries tx_start, giving the UART time to raise tx_busy.
      S_TX_WAIT:
        if (!r_txStart && !tx_busy) w_nextState = (r_txIdx == r_lastIdx) ? S_IDLE : S_TX_LOAD;
      S_PLL_UPD:
        w_nextState = S_IDLE;
      default:
        w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_opcode      <= '0;
      r_args        <= '0;
      r_argIdx      <= '0;
      r_timer       <= '0;
      r_txIdx       <= '0;
      r_lastIdx     <= '0;
      r_txData      <= '0;
      r_txStart     <= 1'b0;
      r_resetHist   <= 1'b0;
      r_errCount    <= '0;
      r_disable     <= 1'b1;
      r_debug       <= 1'b0;
      r_passthrough <= 1'b0;
      r_intPulse    <= 1'b0;
      r_extPulse    <= 1'b0;
      r_veto        <= 3'b001;
      r_pll         <= '0;
    end else begin
      r_txStart   <= 1'b0;
      r_resetHist <= w_snapLoad;
      if ((w_badOp || w_timeout) && r_errCount != 8'hFF) r_errCount <= r_errCount + 8'd1;
      case (r_state)
        S_IDLE:
          if (rx_ready) begin
            r_opcode <= rx_data;
            r_argIdx <= '0;
            r_timer  <= '0;
          end
        S_ARGS:
          if (rx_ready) begin
            r_args   <= w_argShift[(NUM_PLL+1)*8-1:8];
            r_argIdx <= r_argIdx + ARG_W'(1);
            r_timer  <= '0;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        S_EXEC: begin
          r_txIdx <= '0;
          case (r_opcode)
            OP_SET_OUTPUTS: begin
              r_disable <= ~w_a0[0];
              r_debug   <= w_a0[1];
            end
            OP_SET_PLL:         r_pll         <= r_args;
            OP_SET_PASSTHROUGH: r_passthrough <= (w_a0 != 8'd0);
            OP_SET_PMT_VETO:    r_veto        <= w_a0[2:0];
            OP_RESET_PLL:       r_pll         <= '0;
            OP_SET_TEST_INPUTS: begin
              r_intPulse <= w_a0[0];
              r_extPulse <= w_a0[1];
            end
            OP_VERSION:        r_lastIdx <= IDX_W'(VERSION_LEN - 1);
            OP_SEND_HISTOGRAM: r_lastIdx <= IDX_W'(HIST_BYTES - 1);
            OP_READ_STATUS:    r_lastIdx <= IDX_W'(STATUS_LEN - 1);
            default: ;
          endcase
        end
        S_TX_LOAD:
          if (!tx_busy) begin
            r_txStart <= 1'b1;
            r_txData  <= w_replyByte;
          end
        S_TX_WAIT:
          if (!r_txStart && !tx_busy) r_txIdx <= r_txIdx + IDX_W'(1);
        default: ;
      endcase
    end
  end

  assign tx_start                = r_txStart;
  assign tx_data                 = r_txData;
  assign resethist               = r_resetHist;
  assign disable_line_drivers    = r_disable;
  assign enable_debug_outputs    = r_debug;
  assign passthrough             = r_passthrough;
  assign vetopmtlast             = r_veto;
  assign use_internal_test_pulse = r_intPulse;
  assign use_external_test_pulse = r_extPulse;
  assign pll_shifts              = r_pll;
  assign updatepll               = (r_state == S_PLL_UPD);
  assign busy                    = (r_state != S_IDLE);
  assign err_count               = r_errCount;

endmodule
